exe_muldiv_seq: RTL and testbench

Iterative RV32M multiply/divide sequencer beside the EXE stage ALU. It accepts one M-extension operation from ID and runs it over 32 cycles on a shared shift/add-subtract datapath. While it works, it holds the pipeline with a stall line, then presents a registered 32-bit result with its destination register for the EXE→MEM register.

---
 rtl/exe_muldiv_seq.sv | 209 ++++++++++++++++++++
 tb/tb_exe_muldiv_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/exe_muldiv_seq.sv
// exe_muldiv_seq: iterative RV32M multiply/divide sequencer beside the EXE ALU.
// One operation runs over 32 CALC cycles on a shift/add-subtract datapath.
// The pipeline is stalled from acceptance through FIX. The result is then
// presented with its destination register for one done cycle.
// Optional feature: define MULDIV_DIV_EN to build the divider. Without it,
// funct3 4-7 complete in two cycles with result 0.
module exe_muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_addr,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  result_rd_addr
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [2:0]  op;
  logic [4:0]  rd_q;
  logic [31:0] opnd;      // multiplicand for multiply, divisor for divide
  logic [63:0] prod;      // {accumulator, remaining multiplier bits}
  logic        neg_res;   // product / quotient needs negation

`ifdef MULDIV_DIV_EN
  logic [31:0] quo;       // dividend shifts out as quotient bits shift in
  logic [31:0] rem;
  logic        neg_rem;   // remainder takes the dividend sign
  logic        div_zero;
  logic        div_ovf;
  logic [32:0] rem_shift;
  logic [32:0] rem_diff;
  logic [31:0] quo_sel;
  logic [31:0] rem_sel;
`endif

  logic        a_signed;
  logic        b_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [63:0] prod_sel;
  logic [31:0] fix_out;

  // Operand sign handling for the instruction offered in IDLE
  always_comb begin
    a_signed = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    b_signed = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    a_neg    = a_signed && rs1_data[31];
    b_neg    = b_signed && rs2_data[31];
    a_mag    = a_neg ? (~rs1_data + 32'd1) : rs1_data;
    b_mag    = b_neg ? (~rs2_data + 32'd1) : rs2_data;
`ifdef MULDIV_DIV_EN
    div_zero = (rs2_data == '0);
    div_ovf  = b_signed && (rs1_data == 32'h8000_0000) && (rs2_data == '1);
`endif
  end

  // One iteration of shift-add multiply and restoring divide
  always_comb begin
    mul_sum   = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, opnd} : 33'd0);
`ifdef MULDIV_DIV_EN
    rem_shift = {rem, quo[31]};
    rem_diff  = rem_shift - {1'b0, opnd};
`endif
  end

  // Sign fix-up and output selection evaluated in FIX
  always_comb begin
    prod_sel = neg_res ? (~prod + 64'd1) : prod;
`ifdef MULDIV_DIV_EN
    quo_sel  = neg_res ? (~quo + 32'd1) : quo;
    rem_sel  = neg_rem ? (~rem + 32'd1) : rem;
    if (op[2])
      fix_out = op[1] ? rem_sel : quo_sel;
    else
      fix_out = (op == 3'd0) ? prod_sel[31:0] : prod_sel[63:32];
`else
    if (op[2])
      fix_out = '0;
    else
      fix_out = (op == 3'd0) ? prod_sel[31:0] : prod_sel[63:32];
`endif
  end

  // Stall is combinational from start so the accepting cycle is also held
  always_comb begin
    stall = ((state == IDLE) && start && !flush) || (state == CALC) || (state == FIX);
  end

  // Sequencer: operand capture, iteration, fix-up and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      op             <= '0;
      rd_q           <= '0;
      opnd           <= '0;
      prod           <= '0;
      neg_res        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      result         <= '0;
      result_rd_addr <= '0;
`ifdef MULDIV_DIV_EN
      quo            <= '0;
      rem            <= '0;
      neg_rem        <= 1'b0;
`endif
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op      <= funct3;
            rd_q    <= rd_addr;
            cnt     <= '0;
            neg_res <= a_neg ^ b_neg;
            busy    <= 1'b1;
`ifdef MULDIV_DIV_EN
            neg_rem <= a_neg;
            if (funct3[2]) begin
              opnd <= b_mag;
              quo  <= a_mag;
              rem  <= '0;
              // Special cases load final values and skip both CALC and sign fix-up
              if (div_zero) begin
                quo     <= '1;
                rem     <= rs1_data;
                neg_res <= 1'b0;
                neg_rem <= 1'b0;
                state   <= FIX;
              end else if (div_ovf) begin
                quo     <= 32'h8000_0000;
                rem     <= '0;
                neg_res <= 1'b0;
                neg_rem <= 1'b0;
                state   <= FIX;
              end else begin
                state   <= CALC;
              end
            end else begin
              opnd  <= a_mag;
              prod  <= {32'd0, b_mag};
              state <= CALC;
            end
`else
            opnd  <= a_mag;
            prod  <= {32'd0, b_mag};
            state <= funct3[2] ? FIX : CALC;
`endif
          end
        end
        CALC: begin
`ifdef MULDIV_DIV_EN
          if (op[2]) begin
            if (!rem_diff[32]) begin
              rem <= rem_diff[31:0];
              quo <= {quo[30:0], 1'b1};
            end else begin
              rem <= rem_shift[31:0];
              quo <= {quo[30:0], 1'b0};
            end
          end else begin
            prod <= {mul_sum, prod[31:1]};
          end
`else
          prod <= {mul_sum, prod[31:1]};
`endif
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31)
            state <= FIX;
        end
        FIX: begin
          result         <= fix_out;
          result_rd_addr <= rd_q;
          done           <= 1'b1;
          state          <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exe_muldiv_seq.sv
// Directed testbench for exe_muldiv_seq. Divide vectors are selected by MULDIV_DIV_EN.
module tb_exe_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_addr;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  result_rd_addr;

  int total;
  int passed;

  exe_muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
    .flush(flush), .stall(stall), .busy(busy), .done(done),
    .result(result), .result_rd_addr(result_rd_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: issue one op from IDLE (caller is 1 time unit past an edge)
  // and record timing observations. cyc = edges from acceptance to done cycle.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int cyc, output int stall_cnt,
                        output logic stall0, output logic stall_done, output logic done_next);
    funct3 = f; rs1_data = a; rs2_data = b; rd_addr = rd; start = 1'b1;
    #1 stall0 = stall;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; stall_cnt = 0;
    while (!done && cyc < 100) begin
      if (stall) stall_cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    stall_done = stall;
    @(posedge clk); #1;
    done_next = done;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0;
    rs1_data = '0; rs2_data = '0; rd_addr = '0;
    @(posedge clk); #1;
    total++; if (stall !== 1'b0) $display("FAIL reset_stall got %b expected 0", stall); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b expected 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b expected 0", done); else passed++;
    total++; if (result !== 32'h0) $display("FAIL reset_result got %h expected 0", result); else passed++;
    total++; if (result_rd_addr !== 5'd0) $display("FAIL reset_rd got %0d expected 0", result_rd_addr); else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul;
    int c, s; logic s0, sd, dn;
    run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5, c, s, s0, sd, dn);
    total++; if (result !== 32'hFFFF_FFEB) $display("FAIL mul_result got %h expected ffffffeb", result); else passed++;
    total++; if (result_rd_addr !== 5'd5) $display("FAIL mul_rd got %0d expected 5", result_rd_addr); else passed++;
    total++; if (c !== 34) $display("FAIL mul_latency got %0d expected 34", c); else passed++;
    total++; if (s !== 33) $display("FAIL mul_stall_cycles got %0d expected 33", s); else passed++;
    total++; if (s0 !== 1'b1) $display("FAIL mul_stall_start got %b expected 1", s0); else passed++;
    total++; if (sd !== 1'b0) $display("FAIL mul_stall_in_done got %b expected 0", sd); else passed++;
    total++; if (dn !== 1'b0) $display("FAIL mul_done_pulse_width got %b expected 0", dn); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mul_busy_after got %b expected 0", busy); else passed++;
  endtask

  task automatic test_mulh;
    int c, s; logic s0, sd, dn;
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, c, s, s0, sd, dn);
    total++; if (result !== 32'h4000_0000) $display("FAIL mulh_result got %h expected 40000000", result); else passed++;
    run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 5'd7, c, s, s0, sd, dn);
    total++; if (result !== 32'h4000_0000) $display("FAIL mulhu_result got %h expected 40000000", result); else passed++;
    run_op(3'd2, 32'h8000_0000, 32'h8000_0000, 5'd8, c, s, s0, sd, dn);
    total++; if (result !== 32'hC000_0000) $display("FAIL mulhsu_result got %h expected c0000000", result); else passed++;
    total++; if (result_rd_addr !== 5'd8) $display("FAIL mulhsu_rd got %0d expected 8", result_rd_addr); else passed++;
  endtask

`ifdef MULDIV_DIV_EN
  task automatic test_div;
    int c, s; logic s0, sd, dn;
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd13, c, s, s0, sd, dn);
    total++; if (result !== 32'hFFFF_FFFD) $display("FAIL div_result got %h expected fffffffd", result); else passed++;
    total++; if (c !== 34) $display("FAIL div_latency got %0d expected 34", c); else passed++;
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd14, c, s, s0, sd, dn);
    total++; if (result !== 32'hFFFF_FFFF) $display("FAIL rem_result got %h expected ffffffff", result); else passed++;
    run_op(3'd5, 32'hFFFF_FFF9, 32'd2, 5'd15, c, s, s0, sd, dn);
    total++; if (result !== 32'h7FFF_FFFC) $display("FAIL divu_result got %h expected 7ffffffc", result); else passed++;
  endtask

  task automatic test_div_special;
    int c, s; logic s0, sd, dn;
    run_op(3'd4, 32'd5, 32'd0, 5'd16, c, s, s0, sd, dn);
    total++; if (result !== 32'hFFFF_FFFF) $display("FAIL div0_result got %h expected ffffffff", result); else passed++;
    total++; if (c !== 2) $display("FAIL div0_latency got %0d expected 2", c); else passed++;
    total++; if (s !== 1) $display("FAIL div0_stall_cycles got %0d expected 1", s); else passed++;
    run_op(3'd6, 32'd5, 32'd0, 5'd17, c, s, s0, sd, dn);
    total++; if (result !== 32'd5) $display("FAIL rem0_result got %h expected 00000005", result); else passed++;
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, c, s, s0, sd, dn);
    total++; if (result !== 32'h8000_0000) $display("FAIL divovf_result got %h expected 80000000", result); else passed++;
    total++; if (c !== 2) $display("FAIL divovf_latency got %0d expected 2", c); else passed++;
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, c, s, s0, sd, dn);
    total++; if (result !== 32'h0) $display("FAIL removf_result got %h expected 00000000", result); else passed++;
    total++; if (result_rd_addr !== 5'd19) $display("FAIL removf_rd got %0d expected 19", result_rd_addr); else passed++;
  endtask
`else
  task automatic test_div_disabled;
    int c, s; logic s0, sd, dn;
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd13, c, s, s0, sd, dn);
    total++; if (result !== 32'h0) $display("FAIL nodiv_result got %h expected 00000000", result); else passed++;
    total++; if (c !== 2) $display("FAIL nodiv_latency got %0d expected 2", c); else passed++;
    total++; if (result_rd_addr !== 5'd13) $display("FAIL nodiv_rd got %0d expected 13", result_rd_addr); else passed++;
    run_op(3'd7, 32'd5, 32'd0, 5'd17, c, s, s0, sd, dn);
    total++; if (result !== 32'h0) $display("FAIL noremu_result got %h expected 00000000", result); else passed++;
    total++; if (s !== 1) $display("FAIL noremu_stall_cycles got %0d expected 1", s); else passed++;
  endtask
`endif

  task automatic test_flush;
    int c, s, done_seen; logic s0, sd, dn;
    run_op(3'd0, 32'd3, 32'd5, 5'd4, c, s, s0, sd, dn);
    total++; if (result !== 32'd15) $display("FAIL flush_pre_result got %h expected 0000000f", result); else passed++;
    funct3 = 3'd0; rs1_data = 32'h0000_1234; rs2_data = 32'd2; rd_addr = 5'd11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_seen = 0;
    for (int i = 1; i < 10; i++) begin
      if (done) done_seen++;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL flush_busy got %b expected 0", busy); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL flush_stall got %b expected 0", stall); else passed++;
    total++; if (done !== 1'b0 || done_seen !== 0) $display("FAIL flush_done got %b/%0d expected 0/0", done, done_seen); else passed++;
    total++; if (result !== 32'd15) $display("FAIL flush_result_kept got %h expected 0000000f", result); else passed++;
    total++; if (result_rd_addr !== 5'd4) $display("FAIL flush_rd_kept got %0d expected 4", result_rd_addr); else passed++;
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, c, s, s0, sd, dn);
    total++; if (result !== 32'hFFFF_FFFE) $display("FAIL post_flush_result got %h expected fffffffe", result); else passed++;
    total++; if (c !== 34) $display("FAIL post_flush_latency got %0d expected 34", c); else passed++;
  endtask

  task automatic test_reset_mid;
    funct3 = 3'd0; rs1_data = 32'd9; rs2_data = 32'd9; rd_addr = 5'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i < 20; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    total++; if (stall !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL rstmid_ctrl got stall=%b busy=%b done=%b expected 0/0/0", stall, busy, done); else passed++;
    total++; if (result !== 32'h0 || result_rd_addr !== 5'd0)
      $display("FAIL rstmid_result got %h/%0d expected 0/0", result, result_rd_addr); else passed++;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL rstmid_after got busy=%b done=%b expected 0/0", busy, done); else passed++;
  endtask

  task automatic test_back_to_back;
    int cyc, done_cnt, first_done;
    funct3 = 3'd0; rs1_data = 32'd6; rs2_data = 32'd7; rd_addr = 5'd9; start = 1'b1;
    @(posedge clk); #1;
    rs1_data = 32'd100; rd_addr = 5'd10;   // start stays high; these must not be picked up mid-op
    cyc = 1; done_cnt = 0; first_done = 0;
    while (cyc <= 34) begin
      if (done) begin done_cnt++; first_done = cyc; end
      @(posedge clk); #1;
      cyc++;
    end
    total++; if (done_cnt !== 1 || first_done !== 34)
      $display("FAIL b2b_single_done got count=%0d at=%0d expected 1 at 34", done_cnt, first_done); else passed++;
    total++; if (result !== 32'd42 || result_rd_addr !== 5'd9)
      $display("FAIL b2b_first_result got %h/%0d expected 0000002a/9", result, result_rd_addr); else passed++;
    total++; if (busy !== 1'b0 || stall !== 1'b1)
      $display("FAIL b2b_idle_accept got busy=%b stall=%b expected 0/1", busy, stall); else passed++;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL b2b_second_busy got %b expected 1", busy); else passed++;
    cyc = 0;
    while (!done && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    total++; if (result !== 32'd700 || result_rd_addr !== 5'd10)
      $display("FAIL b2b_second_result got %h/%0d expected 000002bc/10", result, result_rd_addr); else passed++;
    @(posedge clk); #1;
  endtask

  initial begin
    total = 0;
    passed = 0;
    test_reset();
    test_mul();
    test_mulh();
`ifdef MULDIV_DIV_EN
    test_div();
    test_div_special();
`else
    test_div_disabled();
`endif
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
